// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// The slave view belongs to the multiplier; the master view belongs to the producer/consumer side.
interface fp_mult_pipe_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] product;
   logic         overflow;
   logic         underflow;
   logic         invalid;
   logic         exception;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, overflow, underflow, invalid, exception
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, overflow, underflow, invalid, exception
   );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 multiplier (unpack / multiply / normalise-round-pack) with
// valid/ready backpressure, round-to-nearest-even and subnormal flush-to-zero.
module fp_mult_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic          clk,
   input  logic          rst_n,
   fp_mult_pipe_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS  = EW'((32'd1 << (EXP_W - 1)) - 32'd1);
   localparam logic signed [EW-1:0] EMAX  = EW'((32'd1 << EXP_W) - 32'd1);
   localparam logic signed [EW-1:0] EZERO = '0;

   typedef enum logic [1:0] {
      CL_NORM = 2'd0,
      CL_NAN  = 2'd1,
      CL_INF  = 2'd2,
      CL_ZERO = 2'd3
   } cls_t;

   function automatic logic f_is_zero(input logic [EXP_W-1:0] e);
      return (e == {EXP_W{1'b0}});
   endfunction

   function automatic logic f_is_inf(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      return (&e) && (f == {MAN_W{1'b0}});
   endfunction

   function automatic logic f_is_nan(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      return (&e) && (f != {MAN_W{1'b0}});
   endfunction

   // ---------------- handshake ----------------
   logic r_v1, r_v2, r_v3;
   logic w_adv0, w_adv1, w_adv2, w_acc;

   assign w_adv2       = !r_v3 || bus.out_ready;
   assign w_adv1       = !r_v2 || w_adv2;
   assign w_adv0       = !r_v1 || w_adv1;
   assign w_acc        = bus.in_valid && w_adv0;
   assign bus.in_ready = w_adv0;

   // ---------------- S1 unpack ----------------
   logic                    w_sa, w_sb;
   logic [EXP_W-1:0]        w_ea, w_eb;
   logic [MAN_W-1:0]        w_fa, w_fb;
   logic signed [EW-1:0]    w_esum;
   cls_t                    w_cls;

   assign w_sa   = bus.a[W-1];
   assign w_sb   = bus.b[W-1];
   assign w_ea   = bus.a[W-2 -: EXP_W];
   assign w_eb   = bus.b[W-2 -: EXP_W];
   assign w_fa   = bus.a[MAN_W-1:0];
   assign w_fb   = bus.b[MAN_W-1:0];
   assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

   // Special-case precedence: NaN or Inf*0 beats Inf, Inf beats zero.
   always_comb begin
      w_cls = CL_NORM;
      if (f_is_nan(w_ea, w_fa) || f_is_nan(w_eb, w_fb) ||
          (f_is_inf(w_ea, w_fa) && f_is_zero(w_eb)) ||
          (f_is_zero(w_ea) && f_is_inf(w_eb, w_fb))) begin
         w_cls = CL_NAN;
      end else if (f_is_inf(w_ea, w_fa) || f_is_inf(w_eb, w_fb)) begin
         w_cls = CL_INF;
      end else if (f_is_zero(w_ea) || f_is_zero(w_eb)) begin
         w_cls = CL_ZERO;
      end else begin
         w_cls = CL_NORM;
      end
   end

   logic                 r_s1_sign;
   cls_t                 r_s1_cls;
   logic signed [EW-1:0] r_s1_esum;
   logic [MAN_W:0]       r_s1_ma, r_s1_mb;

   // Stage 1 valid bit and unpacked operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1      <= 1'b0;
         r_s1_sign <= 1'b0;
         r_s1_cls  <= CL_NORM;
         r_s1_esum <= '0;
         r_s1_ma   <= '0;
         r_s1_mb   <= '0;
      end else begin
         if (w_adv0) r_v1 <= bus.in_valid;
         if (w_acc) begin
            r_s1_sign <= w_sa ^ w_sb;
            r_s1_cls  <= w_cls;
            r_s1_esum <= w_esum;
            r_s1_ma   <= {1'b1, w_fa};
            r_s1_mb   <= {1'b1, w_fb};
         end
      end
   end

   // ---------------- S2 multiply ----------------
   logic                 r_s2_sign;
   cls_t                 r_s2_cls;
   logic signed [EW-1:0] r_s2_esum;
   logic [PW-1:0]        r_s2_prod;

   // Stage 2 valid bit and full-width significand product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2      <= 1'b0;
         r_s2_sign <= 1'b0;
         r_s2_cls  <= CL_NORM;
         r_s2_esum <= '0;
         r_s2_prod <= '0;
      end else begin
         if (w_adv1) r_v2 <= r_v1;
         if (w_adv1 && r_v1) begin
            r_s2_sign <= r_s1_sign;
            r_s2_cls  <= r_s1_cls;
            r_s2_esum <= r_s1_esum;
            r_s2_prod <= r_s1_ma * r_s1_mb;
         end
      end
   end

   // ---------------- S3 normalise / round / pack ----------------
   logic                 w_msb, w_guard, w_sticky, w_inc;
   logic [PW-2:0]        w_norm;
   logic [MAN_W-1:0]     w_mant;
   logic [MAN_W:0]       w_rnd;
   logic signed [EW-1:0] w_exp_f;
   logic [W-1:0]         w_pack;
   logic                 w_ov, w_un, w_inv;

   // Leading one of the product ends up just above bit PW-2 of w_norm.
   assign w_msb    = r_s2_prod[PW-1];
   assign w_norm   = w_msb ? r_s2_prod[PW-2:0] : {r_s2_prod[PW-3:0], 1'b0};
   assign w_mant   = w_norm[PW-2 -: MAN_W];
   assign w_guard  = w_norm[MAN_W];
   assign w_sticky = |w_norm[MAN_W-1:0];
   assign w_inc    = w_guard && (w_sticky || w_mant[0]);
   assign w_rnd    = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_inc};
   assign w_exp_f  = r_s2_esum + {{(EW-1){1'b0}}, w_msb} + {{(EW-1){1'b0}}, w_rnd[MAN_W]};

   // Result selection; a rounding carry leaves the stored mantissa at zero.
   always_comb begin
      w_pack = '0;
      w_ov   = 1'b0;
      w_un   = 1'b0;
      w_inv  = 1'b0;
      if (r_s2_cls == CL_NAN) begin
         w_pack = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         w_inv  = 1'b1;
      end else if (r_s2_cls == CL_INF) begin
         w_pack = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (r_s2_cls == CL_ZERO) begin
         w_pack = {r_s2_sign, {(W-1){1'b0}}};
      end else if (w_exp_f >= EMAX) begin
         w_pack = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_ov   = 1'b1;
      end else if (w_exp_f <= EZERO) begin
         w_pack = {r_s2_sign, {(W-1){1'b0}}};
         w_un   = 1'b1;
      end else begin
         w_pack = {r_s2_sign, w_exp_f[EXP_W-1:0], w_rnd[MAN_W-1:0]};
      end
   end

   logic         r_product_valid;
   logic [W-1:0] r_product;
   logic         r_overflow, r_underflow, r_invalid, r_exception;

   // Output stage; holds its contents while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v3        <= 1'b0;
         r_product   <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_invalid   <= 1'b0;
         r_exception <= 1'b0;
      end else begin
         if (w_adv2) r_v3 <= r_v2;
         if (w_adv2 && r_v2) begin
            r_product   <= w_pack;
            r_overflow  <= w_ov;
            r_underflow <= w_un;
            r_invalid   <= w_inv;
            r_exception <= w_ov | w_un | w_inv;
         end
      end
   end

   assign r_product_valid = r_v3;
   assign bus.out_valid   = r_product_valid;
   assign bus.product     = r_product;
   assign bus.overflow    = r_overflow;
   assign bus.underflow   = r_underflow;
   assign bus.invalid     = r_invalid;
   assign bus.exception   = r_exception;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed-vector bench for fp_mult_pipe (binary32): single ops, stalled stream, async reset.
module tb_fp_mult_pipe;
   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   fp_mult_pipe_if #(.W(32)) ifc();

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic [2:0]  f;   // {overflow, underflow, invalid}
   } vec_t;

   vec_t vec[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Present one op with out_ready=1; returns edges from accept (inclusive) to out_valid.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      ifc.a         = a;
      ifc.b         = b;
      #1;
      check("in_ready_idle", {63'd0, ifc.in_ready}, 64'd1);
      @(posedge clk);
      lat = 1;
      #1;
      ifc.in_valid = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         if (ifc.out_valid) break;
         @(posedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int idx;
      int rx;
      int first_block;
      int stale;
      logic have_hold;
      logic acc;
      logic [31:0] held;

      n_pass  = 0;
      n_total = 0;
      vec[0]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 3'b000};
      vec[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
      vec[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
      vec[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100};
      vec[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010};
      vec[5]  = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 3'b001};
      vec[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
      vec[7]  = '{32'h00000001, 32'h40000000, 32'h00000000, 3'b000};
      vec[8]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000};  // tie, odd -> up
      vec[9]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000};  // tie, even -> stay
      vec[10] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 3'b000};  // rounding carry
      vec[11] = '{32'hC0400000, 32'h40000000, 32'hC0C00000, 3'b000};
      vec[12] = '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 3'b001};
      vec[13] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
      vec[14] = '{32'hFFC00001, 32'h3F800000, 32'h7FC00000, 3'b001};

      rst_n         = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.a         = 32'd0;
      ifc.b         = 32'd0;
      ifc.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
      check("rst_product", {32'd0, ifc.product}, 64'd0);
      check("rst_flags", {60'd0, ifc.overflow, ifc.underflow, ifc.invalid, ifc.exception}, 64'd0);
      check("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);

      // Single ops through the table.
      for (int i = 0; i < 15; i++) begin
         do_op(vec[i].a, vec[i].b, lat);
         check($sformatf("latency[%0d]", i), 64'(lat), 64'd3);
         check($sformatf("product[%0d]", i), {32'd0, ifc.product}, {32'd0, vec[i].p});
         check($sformatf("flags[%0d]", i),
               {60'd0, ifc.overflow, ifc.underflow, ifc.invalid, ifc.exception},
               {60'd0, vec[i].f, |vec[i].f});
      end

      // Six back-to-back ops with the consumer stalled for the first five cycles.
      idx         = 0;
      rx          = 0;
      first_block = -1;
      have_hold   = 1'b0;
      held        = 32'd0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         @(negedge clk);
         ifc.out_ready = (cyc >= 5);
         ifc.in_valid  = (idx < 6);
         if (idx < 6) begin
            ifc.a = vec[idx].a;
            ifc.b = vec[idx].b;
         end else begin
            ifc.a = 32'd0;
            ifc.b = 32'd0;
         end
         #1;
         if (ifc.in_valid && !ifc.in_ready && first_block < 0) first_block = idx;
         if (ifc.out_valid) begin
            if (have_hold) check("stall_stable", {32'd0, ifc.product}, {32'd0, held});
            have_hold = 1'b0;
            if (ifc.out_ready) begin
               if (rx < 6) check($sformatf("stream[%0d]", rx), {32'd0, ifc.product}, {32'd0, vec[rx].p});
               else check("stream_extra", 64'(rx), 64'd5);
               rx++;
            end else begin
               held      = ifc.product;
               have_hold = 1'b1;
            end
         end
         acc = ifc.in_valid && ifc.in_ready;
         @(posedge clk);
         if (acc) idx++;
      end
      @(negedge clk);
      ifc.in_valid = 1'b0;
      check("accepts_before_block", 64'(first_block), 64'd3);
      check("stream_count", 64'(rx), 64'd6);

      // Async reset with three ops in flight.
      ifc.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ifc.in_valid = 1'b1;
         ifc.a        = vec[k].a;
         ifc.b        = vec[k].b;
      end
      @(negedge clk);
      ifc.in_valid = 1'b0;
      #2;
      check("pre_rst_full", {63'd0, ifc.out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {63'd0, ifc.out_valid}, 64'd0);
      check("async_rst_product", {32'd0, ifc.product}, 64'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      ifc.out_ready = 1'b1;
      stale         = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ifc.out_valid) stale++;
      end
      check("no_stale_after_rst", 64'(stale), 64'd0);
      do_op(vec[11].a, vec[11].b, lat);
      check("post_rst_latency", 64'(lat), 64'd3);
      check("post_rst_product", {32'd0, ifc.product}, {32'd0, vec[11].p});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
